// File: rtl/writeback_arbiter.sv
// Purpose : merges ALU results and buffered load responses onto the single
//           register-file write port; tracks outstanding loads for decode.
// Latency : ALU -> write_enable 1 cycle; load response -> write_enable 2 cycles.
// Backpr. : mem_ready drops when the load FIFO is full; alu_ready drops once
//           the FIFO head has waited STARVE_LIMIT cycles.
// Ports   : clock/reset (sync, active-high); alu_* and mem_* valid/ready
//           inputs; ld_issue_* marks a pending load; addr_rs1/2 ->
//           rs1/rs2_busy; addr_rd/data_rd/write_enable registered write
//           port; sb_err sticky double-issue flag.
module writeback_arbiter #(
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  addr_rs1,
  input  logic [4:0]  addr_rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  addr_rd,
  output logic [31:0] data_rd,
  output logic        write_enable,
  output logic        sb_err
);

  localparam int IDX_W = $clog2(LQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_lq_rd   [LQ_DEPTH];
  logic [31:0]      r_lq_data [LQ_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [AGE_W-1:0] r_age;
  logic [31:0]      r_pending;
  logic             r_wb_load;   // current write strobe came from a load

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_alu_win;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_head_data;
  logic [4:0]       w_win_rd;
  logic [31:0]      w_win_data;
  logic [31:0]      w_set_vec;
  logic [31:0]      w_clr_vec;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

  assign mem_ready = !reset && !w_full;
  assign alu_ready = !reset && (r_age < AGE_W'(STARVE_LIMIT));

  assign w_push    = mem_valid && mem_ready;
  assign w_alu_win = alu_valid && alu_ready;
  assign w_pop     = !reset && !w_alu_win && !w_empty;

  assign w_head_rd   = r_lq_rd[r_rd_ptr[IDX_W-1:0]];
  assign w_head_data = r_lq_data[r_rd_ptr[IDX_W-1:0]];
  assign w_win_rd    = w_alu_win ? alu_rd   : w_head_rd;
  assign w_win_data  = w_alu_win ? alu_data : w_head_data;

  // Pending bit clears only once the load's write strobe has been seen by
  // the register file, so busy never drops before the data is committed.
  assign w_clr_vec = (write_enable && r_wb_load) ? (32'd1 << addr_rd) : 32'd0;
  assign w_set_vec = (ld_issue_valid && ld_issue_rd != 5'd0) ?
                     (32'd1 << ld_issue_rd) : 32'd0;

  assign rs1_busy = r_pending[addr_rs1];
  assign rs2_busy = r_pending[addr_rs2];

  // FIFO storage: contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_lq_rd[r_wr_ptr[IDX_W-1:0]]   <= mem_rd;
      r_lq_data[r_wr_ptr[IDX_W-1:0]] <= mem_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Head age: how long the oldest response has been passed over.
  always_ff @(posedge clock) begin
    if (reset || w_empty || w_pop) begin
      r_age <= '0;
    end else if (r_age < AGE_W'(STARVE_LIMIT)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= 1'b0;
      addr_rd      <= 5'd0;
      data_rd      <= 32'd0;
      r_wb_load    <= 1'b0;
    end else if (w_alu_win || w_pop) begin
      write_enable <= (w_win_rd != 5'd0);
      addr_rd      <= w_win_rd;
      data_rd      <= w_win_data;
      r_wb_load    <= w_pop && (w_head_rd != 5'd0);
    end else begin
      write_enable <= 1'b0;
      r_wb_load    <= 1'b0;
    end
  end

  // Set is OR-ed after clear so a re-issue at the clearing edge wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= 32'd0;
      sb_err    <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
      if (ld_issue_valid && ld_issue_rd != 5'd0 && r_pending[ld_issue_rd])
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Purpose : directed bench for writeback_arbiter with hand-computed expectations.
// Latency : inputs driven 1 time unit after each rising edge, outputs checked 1 unit later.
// Backpr. : exercises mem_ready full-stall and alu_ready starvation guard.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  addr_rs1;
  logic [4:0]  addr_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        write_enable;
  logic        sb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  writeback_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_rd    (ld_issue_rd),
    .addr_rs1       (addr_rs1),
    .addr_rs2       (addr_rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .addr_rd        (addr_rd),
    .data_rd        (data_rd),
    .write_enable   (write_enable),
    .sb_err         (sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0;
    addr_rs1 = 5'd0; addr_rs2 = 5'd0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_we",       write_enable, 0);
    chk("rst_addr",     addr_rd, 0);
    chk("rst_data",     data_rd, 0);
    chk("rst_sberr",    sb_err, 0);
    chk("rst_memrdy",   mem_ready, 0);
    chk("rst_alurdy",   alu_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_memrdy", mem_ready, 1);
    chk("post_rst_alurdy", alu_ready, 1);

    // ALU only
    tick(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    chk("alu_rdy", alu_ready, 1);
    chk("alu_we_before", write_enable, 0);
    tick(); alu_valid = 1'b0; #1;
    chk("alu_we",   write_enable, 1);
    chk("alu_addr", addr_rd, 5);
    chk("alu_data", data_rd, 32'hDEADBEEF);
    chk("alu_rdy2", alu_ready, 1);
    tick(); #1;
    chk("alu_idle_we",   write_enable, 0);
    chk("alu_idle_addr", addr_rd, 5);
    chk("alu_idle_data", data_rd, 32'hDEADBEEF);

    // Load path and scoreboard, rd=7
    tick(); ld_issue_valid = 1'b1; ld_issue_rd = 5'd7; addr_rs1 = 5'd7; addr_rs2 = 5'd0; #1;
    chk("ld7_busy_same_cycle", rs1_busy, 0);
    tick(); ld_issue_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234; #1;
    chk("ld7_busy", rs1_busy, 1);
    chk("x0_busy", rs2_busy, 0);
    chk("ld7_memrdy", mem_ready, 1);
    tick(); mem_valid = 1'b0; #1;
    chk("ld7_no_bypass", write_enable, 0);
    chk("ld7_busy2", rs1_busy, 1);
    tick(); #1;
    chk("ld7_we",   write_enable, 1);
    chk("ld7_addr", addr_rd, 7);
    chk("ld7_data", data_rd, 32'h1234);
    chk("ld7_busy_during_we", rs1_busy, 1);
    tick(); #1;
    chk("ld7_we_off", write_enable, 0);
    chk("ld7_busy_clr", rs1_busy, 0);

    // rd=0 on the ALU path
    tick(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF; #1;
    tick(); alu_valid = 1'b0; #1;
    chk("alu_x0_we", write_enable, 0);

    // rd=0 on the load path; rd=0 issues never mark pending nor raise sb_err
    tick(); mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hAB;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0; addr_rs1 = 5'd0; #1;
    tick(); mem_valid = 1'b0; #1;
    chk("ld_x0_busy",  rs1_busy, 0);
    chk("ld_x0_sberr", sb_err, 0);
    tick(); ld_issue_valid = 1'b0; #1;
    chk("ld_x0_we",    write_enable, 0);
    chk("ld_x0_sberr2", sb_err, 0);
    tick(); #1;
    chk("ld_x0_we2",   write_enable, 0);
    chk("ld_x0_memrdy", mem_ready, 1);

    // FIFO full and starvation guard, ALU held valid
    tick(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0; #1;
    chk("full_c0_memrdy", mem_ready, 1);
    chk("full_c0_alurdy", alu_ready, 1);
    tick(); mem_rd = 5'd11; mem_data = 32'hA1; #1;
    chk("full_c1_alurdy", alu_ready, 1);
    chk("full_c1_we",     write_enable, 1);
    chk("full_c1_addr",   addr_rd, 3);
    tick(); mem_rd = 5'd12; mem_data = 32'hA2; #1;
    chk("full_c2_alurdy", alu_ready, 1);
    tick(); mem_rd = 5'd13; mem_data = 32'hA3; #1;
    chk("full_c3_memrdy", mem_ready, 1);
    chk("full_c3_alurdy", alu_ready, 1);
    tick(); mem_rd = 5'd14; mem_data = 32'hA4; #1;
    chk("full_memrdy_low", mem_ready, 0);
    chk("starve_alurdy_low", alu_ready, 0);
    chk("full_c4_addr", addr_rd, 3);
    tick(); alu_valid = 1'b0; mem_valid = 1'b0; #1;
    chk("starve_pop_we",   write_enable, 1);
    chk("starve_pop_addr", addr_rd, 10);
    chk("starve_pop_data", data_rd, 32'hA0);
    chk("starve_alurdy_back", alu_ready, 1);
    chk("full_memrdy_back",   mem_ready, 1);
    tick(); #1;
    chk("drain1_addr", addr_rd, 11);
    chk("drain1_data", data_rd, 32'hA1);
    tick(); #1;
    chk("drain2_addr", addr_rd, 12);
    tick(); #1;
    chk("drain3_addr", addr_rd, 13);
    chk("drain3_data", data_rd, 32'hA3);
    tick(); #1;
    chk("drain_empty_we", write_enable, 0);

    // Double issue to rd=9
    tick(); ld_issue_valid = 1'b1; ld_issue_rd = 5'd9; addr_rs2 = 5'd9; #1;
    chk("dbl_sberr0", sb_err, 0);
    tick(); #1;
    chk("dbl_busy", rs2_busy, 1);
    chk("dbl_sberr1", sb_err, 0);
    tick(); ld_issue_valid = 1'b0; #1;
    chk("dbl_sberr_set", sb_err, 1);
    tick(); #1;
    chk("dbl_sberr_sticky", sb_err, 1);
    chk("dbl_busy_held", rs2_busy, 1);

    // Re-issue of rd=20 at the edge that would clear it: set wins
    tick(); ld_issue_valid = 1'b1; ld_issue_rd = 5'd20; addr_rs1 = 5'd20; #1;
    tick(); ld_issue_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h20; #1;
    chk("sw_busy", rs1_busy, 1);
    tick(); mem_valid = 1'b0; #1;
    chk("sw_we_before", write_enable, 0);
    tick(); ld_issue_valid = 1'b1; ld_issue_rd = 5'd20; #1;
    chk("sw_we",   write_enable, 1);
    chk("sw_addr", addr_rd, 20);
    tick(); ld_issue_valid = 1'b0; #1;
    chk("sw_set_wins", rs1_busy, 1);
    chk("sw_we_off",   write_enable, 0);
    tick(); #1;
    chk("sw_busy_held", rs1_busy, 1);

    // Reset mid-burst with two entries queued
    tick(); alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'hB0; #1;
    tick(); mem_rd = 5'd22; mem_data = 32'hB1; #1;
    chk("mr_alurdy", alu_ready, 1);
    tick(); reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; #1;
    chk("mr_memrdy_rst", mem_ready, 0);
    chk("mr_alurdy_rst", alu_ready, 0);
    tick(); reset = 1'b0; #1;
    chk("mr_we",     write_enable, 0);
    chk("mr_addr",   addr_rd, 0);
    chk("mr_sberr",  sb_err, 0);
    chk("mr_busy20", rs1_busy, 0);
    chk("mr_busy9",  rs2_busy, 0);
    chk("mr_memrdy", mem_ready, 1);
    chk("mr_alurdy2", alu_ready, 1);
    tick(); #1;
    chk("mr_no_stale_write", write_enable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
